// File: rtl/rc_unit.sv
// rc_unit: shared XY route computation for one router input port.
// Serves one granted VC at a time: capture in IDLE, compute/write in CALC.
// Ports:
//   clk_i            clock, rising edge
//   rs_i             synchronous active-high reset
//   rc_ens_i         per-VC RC grant (one-hot or zero in normal use)
//   head_dsts_i      per-VC head destination {dst_y, dst_x}
//   cur_x_i/cur_y_i  this router's coordinates
//   route_clears_i   per-VC clear of the stored route valid bit
//   rc_dones_o       one-cycle pulse when a VC's route is written
//   out_ports_o      per-VC stored port (0 L, 1 N, 2 E, 3 S, 4 W)
//   route_valids_o   per-VC stored route valid
module rc_unit #(
  parameter int no_vc  = 12,
  parameter int addr_w = 4
) (
  input  logic                      clk_i,
  input  logic                      rs_i,
  input  logic [no_vc-1:0]          rc_ens_i,
  input  logic [no_vc*2*addr_w-1:0] head_dsts_i,
  input  logic [addr_w-1:0]         cur_x_i,
  input  logic [addr_w-1:0]         cur_y_i,
  input  logic [no_vc-1:0]          route_clears_i,
  output logic [no_vc-1:0]          rc_dones_o,
  output logic [no_vc*3-1:0]        out_ports_o,
  output logic [no_vc-1:0]          route_valids_o
);

  localparam int IdxW = (no_vc > 1) ? $clog2(no_vc) : 1;

  localparam logic [2:0] PORT_L = 3'd0;
  localparam logic [2:0] PORT_N = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_S = 3'd3;
  localparam logic [2:0] PORT_W = 3'd4;

  typedef enum logic {IDLE, CALC} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [2*addr_w-1:0]    dst_q, dst_d;
  logic [addr_w-1:0]      cx_q, cx_d;
  logic [addr_w-1:0]      cy_q, cy_d;
  logic [no_vc-1:0]       rc_dones_q, rc_dones_d;
  logic [no_vc*3-1:0]     out_ports_q, out_ports_d;
  logic [no_vc-1:0]       route_valids_q, route_valids_d;

  logic [no_vc-1:0]       eligible;
  logic [IdxW-1:0]        sel;
  logic [addr_w-1:0]      dx, dy;
  logic [2:0]             port;

  assign eligible = rc_ens_i & ~route_valids_q;
  assign dx       = dst_q[addr_w-1:0];
  assign dy       = dst_q[2*addr_w-1:addr_w];

  // Lowest eligible index wins; scanning downward leaves the lowest last.
  always_comb begin
    sel = '0;
    for (int i = no_vc - 1; i >= 0; i--) begin
      if (eligible[i]) sel = IdxW'(i);
    end
  end

  always_comb begin
    port = PORT_L;
    if (dx > cx_q)      port = PORT_E;
    else if (dx < cx_q) port = PORT_W;
    else if (dy > cy_q) port = PORT_N;
    else if (dy < cy_q) port = PORT_S;
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    dst_d          = dst_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    rc_dones_d     = '0;
    out_ports_d    = out_ports_q;
    // Clears apply first so a same-edge write to that VC overrides them.
    route_valids_d = route_valids_q & ~route_clears_i;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          idx_d   = sel;
          dst_d   = head_dsts_i[int'(sel)*2*addr_w +: 2*addr_w];
          cx_d    = cur_x_i;
          cy_d    = cur_y_i;
          state_d = CALC;
        end
      end
      CALC: begin
        out_ports_d[int'(idx_q)*3 +: 3] = port;
        route_valids_d[idx_q]           = 1'b1;
        rc_dones_d[idx_q]               = 1'b1;
        state_d                         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rs_i) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      dst_q          <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      rc_dones_q     <= '0;
      out_ports_q    <= '0;
      route_valids_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      dst_q          <= dst_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      rc_dones_q     <= rc_dones_d;
      out_ports_q    <= out_ports_d;
      route_valids_q <= route_valids_d;
    end
  end

  assign rc_dones_o     = rc_dones_q;
  assign out_ports_o    = out_ports_q;
  assign route_valids_o = route_valids_q;

endmodule

// File: tb/tb_rc_unit.sv
// Self-checking bench for rc_unit: expected completions are queued when a
// grant is driven and matched against each rc_dones pulse.
module tb_rc_unit;

  localparam int NV = 12;
  localparam int AW = 4;

  logic                 clk_i = 1'b0;
  logic                 rs_i;
  logic [NV-1:0]        rc_ens_i;
  logic [NV*2*AW-1:0]   head_dsts_i;
  logic [AW-1:0]        cur_x_i, cur_y_i;
  logic [NV-1:0]        route_clears_i;
  logic [NV-1:0]        rc_dones_o;
  logic [NV*3-1:0]      out_ports_o;
  logic [NV-1:0]        route_valids_o;

  rc_unit #(.no_vc(NV), .addr_w(AW)) dut (
    .clk_i          (clk_i),
    .rs_i           (rs_i),
    .rc_ens_i       (rc_ens_i),
    .head_dsts_i    (head_dsts_i),
    .cur_x_i        (cur_x_i),
    .cur_y_i        (cur_y_i),
    .route_clears_i (route_clears_i),
    .rc_dones_o     (rc_dones_o),
    .out_ports_o    (out_ports_o),
    .route_valids_o (route_valids_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         vc;
    logic [2:0] port;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference XY routing: 0 L, 1 N, 2 E, 3 S, 4 W.
  function automatic logic [2:0] xy_port(input int dx, input int dy, input int cx, input int cy);
    if (dx > cx) return 3'd2;
    if (dx < cx) return 3'd4;
    if (dy > cy) return 3'd1;
    if (dy < cy) return 3'd3;
    return 3'd0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_dst(input int vc, input int x, input int y);
    head_dsts_i[vc*2*AW +: 2*AW] = {AW'(y), AW'(x)};
  endtask

  task automatic expect_done(input int vc, input int x, input int y, input int at_cyc);
    exp_t e;
    e.vc   = vc;
    e.port = xy_port(x, y, int'(cur_x_i), int'(cur_y_i));
    e.cyc  = at_cyc;
    sb.push_back(e);
  endtask

  task automatic clear_all();
    route_clears_i = '1;
    tick();
    route_clears_i = '0;
    tick();
  endtask

  // Completion monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rc_dones_o != '0) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(rc_dones_o), 64'd0);
      end else begin
        exp_t e;
        logic [63:0] onehot;
        e = sb.pop_front();
        onehot = 64'd1 << e.vc;
        chk("done_vec", 64'(rc_dones_o), onehot);
        chk("port", 64'(out_ports_o[e.vc*3 +: 3]), 64'(e.port));
        chk("valid", 64'(route_valids_o[e.vc]), 64'd1);
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  int c;
  int dsts [5][2] = '{'{5, 0}, '{0, 0}, '{2, 7}, '{2, 0}, '{2, 2}};

  initial begin
    rs_i = 1'b1;
    rc_ens_i = '0;
    head_dsts_i = '0;
    cur_x_i = 4'd2;
    cur_y_i = 4'd2;
    route_clears_i = '0;
    repeat (3) tick();
    rs_i = 1'b0;

    // Idle after reset: nothing moves.
    repeat (10) tick();
    @(negedge clk_i);
    chk("idle_dones", 64'(rc_dones_o), 64'd0);
    chk("idle_ports", 64'(out_ports_o), 64'd0);
    chk("idle_valids", 64'(route_valids_o), 64'd0);

    // Each XY direction on VC 3; scramble the destination after capture.
    for (int k = 0; k < 5; k++) begin
      tick();
      set_dst(3, dsts[k][0], dsts[k][1]);
      rc_ens_i = 12'h008;
      c = cyc;
      expect_done(3, dsts[k][0], dsts[k][1], c + 2);
      tick();
      rc_ens_i = '0;
      set_dst(3, 9, 9);
      repeat (3) tick();
      route_clears_i = 12'h008;
      tick();
      route_clears_i = '0;
    end

    // Held grant: single completion, then clear triggers one recompute.
    set_dst(5, 2, 0);
    rc_ens_i = 12'h020;
    c = cyc;
    expect_done(5, 2, 0, c + 2);
    repeat (8) tick();
    @(negedge clk_i);
    chk("held_valid", 64'(route_valids_o[5]), 64'd1);
    tick();
    route_clears_i = 12'h020;
    c = cyc;
    expect_done(5, 2, 0, c + 3);
    tick();
    route_clears_i = '0;
    @(negedge clk_i);
    chk("cleared_valid", 64'(route_valids_o[5]), 64'd0);
    chk("kept_port", 64'(out_ports_o[5*3 +: 3]), 64'd3);
    repeat (4) tick();
    rc_ens_i = '0;
    tick();
    clear_all();

    // Back to back: VC 0 then VC 11.
    set_dst(0, 3, 2);
    set_dst(11, 1, 2);
    rc_ens_i = 12'h001;
    c = cyc;
    expect_done(0, 3, 2, c + 2);
    expect_done(11, 1, 2, c + 4);
    tick();
    tick();
    rc_ens_i = 12'h800;
    tick();
    rc_ens_i = '0;
    repeat (4) tick();
    clear_all();

    // Multi-bit grant, lowest first; clear colliding with the write.
    set_dst(1, 2, 7);
    set_dst(2, 2, 0);
    rc_ens_i = 12'h006;
    c = cyc;
    expect_done(1, 2, 7, c + 2);
    expect_done(2, 2, 0, c + 4);
    tick();
    route_clears_i = 12'h002;
    tick();
    route_clears_i = '0;
    @(negedge clk_i);
    chk("collide_valid", 64'(route_valids_o[1]), 64'd1);
    tick();
    rc_ens_i = '0;
    repeat (4) tick();
    @(negedge clk_i);
    chk("both_valid", 64'(route_valids_o[2:1]), 64'd3);
    tick();
    clear_all();

    // Reset in CALC aborts.
    set_dst(4, 6, 2);
    rc_ens_i = 12'h010;
    tick();
    rc_ens_i = '0;
    rs_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("rst_dones", 64'(rc_dones_o), 64'd0);
    chk("rst_ports", 64'(out_ports_o), 64'd0);
    chk("rst_valids", 64'(route_valids_o), 64'd0);
    tick();
    rs_i = 1'b0;
    set_dst(4, 2, 2);
    rc_ens_i = 12'h010;
    c = cyc;
    expect_done(4, 2, 2, c + 2);
    tick();
    rc_ens_i = '0;
    repeat (5) tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rc_unit.md
# rc_unit

Shared route-computation engine for one router input port. It sits directly downstream of the input-port RC/VC arbiter and consumes its one-hot per-VC `rc_ens`. For the granted VC it computes a dimension-ordered (XY) output port from the head-flit destination, stores that port per VC, and returns a one-cycle `rc_dones` pulse to the arbiter, which then moves the VC on to VC allocation.

## Interface
- `no_vc`, default 12: virtual channels per input port.
- `addr_w`, default 4: width of each mesh coordinate (x and y).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rs`  in  1  synchronous, active-high reset.
- `rc_ens`  in  no_vc  per-VC RC grant from the arbiter; one-hot or all-zero in normal use.
- `head_dsts`  in  no_vc*2*addr_w  head destination per VC; slice i is bits [i*2*addr_w +: 2*addr_w] = {dst_y, dst_x}, with dst_x in the low addr_w bits.
- `cur_x`, `cur_y`  in  addr_w each  this router's coordinates.
- `route_clears`  in  no_vc  per-VC clear of the stored route; pulsed when the tail flit leaves.
- `rc_dones`  out  no_vc  one-cycle pulse per VC when its route is written.
- `out_ports`  out  no_vc*3  stored route per VC; slice i is bits [i*3 +: 3].
- `route_valids`  out  no_vc  the stored route for VC i is valid.

## Operation
- Port encoding (3 bits): 0 local, 1 north (+y), 2 east (+x), 3 south (−y), 4 west (−x). Values 5–7 are never produced.
- XY rule, with unsigned comparisons:
  - dst_x > cur_x → east; dst_x < cur_x → west.
  - Otherwise dst_y > cur_y → north; dst_y < cur_y → south.
  - Otherwise → local.
- FSM with two states:
  - **IDLE**: form the eligible mask = `rc_ens & ~route_valids`. If it is nonzero, capture the lowest set index, that VC's `head_dsts` slice, `cur_x` and `cur_y`, then go to CALC. If the mask is zero, stay in IDLE.
  - **CALC**: compute the port from the captured values and write it to `out_ports[idx]`. Set `route_valids[idx]` and drive `rc_dones` with only bit idx set on the next edge. Return to IDLE.
- `rc_dones` is registered and returns to 0 one cycle after it is set.
- A VC whose `route_valids` bit is set is never recomputed, even if its `rc_ens` bit stays high.
- `rc_ens` dropping while in CALC does not abort the computation; the captured request completes.
- More than one `rc_ens` bit high (arbiter error): serve the lowest eligible index. The others wait and are served later if still asserted.
- `route_clears[i]` clears `route_valids[i]` on the next edge; `out_ports[i]` keeps its value.
- Clear and write to the same VC on the same edge: the write wins, and `route_valids[i]` ends at 1.
- Clear to a VC other than the one being written: both take effect.
- Changes to `head_dsts`, `cur_x` or `cur_y` after capture do not affect the in-flight result.

## Timing
- Reset (`rs` high at an edge): state IDLE; `rc_dones`, `out_ports` and `route_valids` all 0; captured index and destination cleared. Reset takes priority over every other event.
- Reset during CALC aborts the computation: no `rc_dones` pulse and no write.
- Latency for a request seen in IDLE in cycle 0 (`rc_ens[i]` = 1, `route_valids[i]` = 0):
  - End of cycle 0: capture.
  - Cycle 1: CALC.
  - Cycle 2: `out_ports[i]` and `route_valids[i]` = 1 visible, and `rc_dones[i]` = 1.
  - Cycle 3: `rc_dones[i]` = 0.
- Throughput: one route every 2 cycles. The FSM is already back in IDLE in cycle 2 and can capture VC j ≠ i then.
- In cycle 2 VC i is already masked by `route_valids`, so an arbiter still asserting `rc_ens[i]` causes no repeat.
- At most one `rc_dones` bit is high in any cycle.

## Test plan
- Reset, then `rc_ens` = 0 for 10 cycles → all outputs remain 0 and no `rc_dones` pulse occurs.
- cur = (2,2); grant VC 3 with dst (x=5, y=0) → in cycle 2, `out_ports[3]` = 2 (east), `route_valids[3]` = 1 and `rc_dones` = 0x008 for exactly one cycle. Repeat with dst (0,0) → west, (2,7) → north, (2,0) → south, (2,2) → local.
- Hold `rc_ens[5]` high for 8 cycles → exactly one `rc_dones[5]` pulse. Then pulse `route_clears[5]` → `route_valids[5]` = 0, and a recompute with a second `rc_dones[5]` pulse follows 2 cycles after the clear is registered.
- Grant VC 0 then VC 11 back to back, with `rc_ens` moving to bit 11 in cycle 2 → `rc_dones` pulses in cycles 2 and 4 with the correct ports for each VC.
- Assert `rc_ens` = 0x006 → VC 1 is served first and VC 2 second. `route_clears[1]` asserted on the same edge as VC 1's write → `route_valids[1]` = 1.
- Assert `rs` during CALC → no `rc_dones` pulse, outputs 0; after release, a new grant completes normally.
